// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, datapath select encodings and the decoder output bundle.
package core_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StExecU,
        StAluWb,
        StJalr,
        StJal,
        StBranch,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpUType = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARs1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SrcBRegB = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        ir_write;
        logic        pc_update;
        logic        branch;
        logic        reg_write;
        logic        adr_src;
        src_a_e      alu_src_a;
        src_b_e      alu_src_b;
        result_src_e result_src;
        imm_src_e    imm_src;
        alu_op_e     alu_op;
        logic [2:0]  alu_funct3;
        logic        instr_done;
        logic        trap;
    } ctrl_out_t;

    // Immediate format implied by the opcode; formats without an immediate fall back to I.
    function automatic imm_src_e imm_src_for(input logic [6:0] op);
        unique case (op)
            OP_STORE:        return ImmS;
            OP_BRANCH:       return ImmB;
            OP_JAL:          return ImmJ;
            OP_LUI, OP_AUIPC: return ImmU;
            default:         return ImmI;
        endcase
    endfunction

    // Dispatch target out of DECODE; any unknown opcode parks in TRAP.
    function automatic state_e decode_next(input logic [6:0] op);
        unique case (op)
            OP_LOAD, OP_STORE: return StMemAdr;
            OP_R:              return StExecR;
            OP_I:              return StExecI;
            OP_LUI, OP_AUIPC:  return StExecU;
            OP_JAL:            return StJal;
            OP_JALR:           return StJalr;
            OP_BRANCH:         return StBranch;
            default:           return StTrap;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decode for the multicycle control FSM: maps the
// current state (plus op/funct3 and mem_ready where needed) to datapath controls.
module mc_ctrl_outdec
    import core_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 7
) (
    input  state_e         state_i,
    input  logic [OPW-1:0] op_i,
    input  logic [2:0]     funct3_i,
    input  logic           mem_ready_i,
    output ctrl_out_t      ctrl_o
);

    // Per-state control decode; everything not set below stays at its default.
    always_comb begin
        ctrl_o            = '0;
        ctrl_o.alu_funct3 = funct3_i;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.alu_src_a  = SrcAPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.result_src = ResAluResult;
                // IR/PC load only on the cycle the fetch completes.
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_update  = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_a = SrcAOldPc;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.imm_src   = imm_src_for(op_i);
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                // Stores need the split S immediate to form the address.
                ctrl_o.imm_src   = op_i[5] ? ImmS : ImmI;
            end
            StMemRead: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = ResAluOut;
            end
            StMemWb: begin
                ctrl_o.result_src = ResData;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StMemWrite: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            StExecR: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBRegB;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StExecI: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StExecU: begin
                ctrl_o.alu_src_a  = SrcAOldPc;
                ctrl_o.alu_src_b  = SrcBImm;
                ctrl_o.alu_op     = AluOpUType;
                ctrl_o.imm_src    = ImmU;
                // op[5] distinguishes LUI (1) from AUIPC (0) for the ALU decoder.
                ctrl_o.alu_funct3 = {2'b00, op_i[5]};
            end
            StAluWb: begin
                ctrl_o.result_src = ResAluOut;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StJalr: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.imm_src   = ImmI;
            end
            StJal: begin
                // Target already sits in ALUOut; ALU computes OldPC+4 for the link.
                ctrl_o.alu_src_a  = SrcAOldPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.result_src = ResAluOut;
                ctrl_o.pc_update  = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a  = SrcARs1;
                ctrl_o.alu_src_b  = SrcBRegB;
                ctrl_o.alu_op     = AluOpSub;
                ctrl_o.result_src = ResAluOut;
                ctrl_o.branch     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StTrap: begin
                ctrl_o.trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: state register and next-state logic. Output decode
// lives in mc_ctrl_outdec; strobes are forced low while reset is asserted.
module mc_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int unsigned RESET_STATE_FETCH = 1,
    parameter int unsigned OPW               = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op_i,
    input  logic [2:0]     funct3_i,
    input  logic           mem_ready_i,
    output logic           mem_req_o,
    output logic           mem_write_o,
    output logic           ir_write_o,
    output logic           pc_update_o,
    output logic           branch_o,
    output logic           reg_write_o,
    output logic           adr_src_o,
    output logic [1:0]     alu_src_a_o,
    output logic [1:0]     alu_src_b_o,
    output logic [1:0]     result_src_o,
    output logic [2:0]     imm_src_o,
    output logic [1:0]     alu_op_o,
    output logic [2:0]     alu_funct3_o,
    output logic           instr_done_o,
    output logic           trap_o
);

    // Reserved parameter: the FSM resets to FETCH whatever the value.
    localparam state_e ResetState = (RESET_STATE_FETCH != 0) ? StFetch : StFetch;

    state_e    state_q, state_d;
    ctrl_out_t ctrl;

    // Next-state: memory states hold until mem_ready; TRAP is absorbing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready_i) state_d = StDecode;
            StDecode:   state_d = decode_next(op_i);
            StMemAdr:   state_d = op_i[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready_i) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StExecU:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJalr:     state_d = StJal;
            StJal:      state_d = StAluWb;
            StBranch:   state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    // State register with asynchronous reset to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    mc_ctrl_outdec #(
        .OPW (OPW)
    ) u_outdec (
        .state_i     (state_q),
        .op_i        (op_i),
        .funct3_i    (funct3_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    // Strobes are gated by rst_n so an abort drops them without waiting for a clock.
    assign mem_req_o    = ctrl.mem_req    & rst_n;
    assign mem_write_o  = ctrl.mem_write  & rst_n;
    assign ir_write_o   = ctrl.ir_write   & rst_n;
    assign pc_update_o  = ctrl.pc_update  & rst_n;
    assign branch_o     = ctrl.branch     & rst_n;
    assign reg_write_o  = ctrl.reg_write  & rst_n;
    assign instr_done_o = ctrl.instr_done & rst_n;
    assign trap_o       = ctrl.trap       & rst_n;

    assign adr_src_o    = ctrl.adr_src;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign result_src_o = ctrl.result_src;
    assign imm_src_o    = ctrl.imm_src;
    assign alu_op_o     = ctrl.alu_op;
    assign alu_funct3_o = ctrl.alu_funct3;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction cycle-by-cycle output vectors.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       mem_req, mem_write, ir_write, pc_update, branch, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0] imm_src, alu_funct3;
    logic       instr_done, trap;

    int checks;
    int failures;

    mc_ctrl_fsm #(
        .RESET_STATE_FETCH (1),
        .OPW               (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_i         (op),
        .funct3_i     (funct3),
        .mem_ready_i  (mem_ready),
        .mem_req_o    (mem_req),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .pc_update_o  (pc_update),
        .branch_o     (branch),
        .reg_write_o  (reg_write),
        .adr_src_o    (adr_src),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .result_src_o (result_src),
        .imm_src_o    (imm_src),
        .alu_op_o     (alu_op),
        .alu_funct3_o (alu_funct3),
        .instr_done_o (instr_done),
        .trap_o       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs in the same order pk() packs its arguments.
    logic [22:0] obs;
    assign obs = {mem_req, mem_write, ir_write, pc_update, branch, reg_write, adr_src,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_op, alu_funct3,
                  instr_done, trap};

    function automatic logic [22:0] pk(input logic rq, input logic wr, input logic irw,
                                       input logic pcu, input logic br, input logic rw,
                                       input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [2:0] imm, input logic [1:0] aop,
                                       input logic [2:0] f3, input logic dn,
                                       input logic tr);
        return {rq, wr, irw, pcu, br, rw, adr, a, b, res, imm, aop, f3, dn, tr};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b000,0,0)) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs,
                     pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b000,0,0));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_r();
        logic [22:0] ev [0:3];
        op = 7'b0110011; funct3 = 3'b000;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b000,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,2'b00,3'b000,0,0);
        ev[2] = pk(0,0,0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,2'b10,3'b000,0,0);
        ev[3] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b000,1,0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL add cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_alu_i();
        logic [22:0] ev [0:3];
        op = 7'b0010011; funct3 = 3'b111;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b111,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,2'b00,3'b111,0,0);
        ev[2] = pk(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b10,3'b111,0,0);
        ev[3] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b111,1,0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL andi cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [22:0] ev [0:8];
        logic        rdy [0:8];
        op = 7'b0000011; funct3 = 3'b010;
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ev[0] = pk(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        ev[1] = ev[0];
        ev[2] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        ev[3] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,2'b00,3'b010,0,0);
        ev[4] = pk(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b00,3'b010,0,0);
        ev[5] = pk(1,0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,3'b010,0,0);
        ev[6] = ev[5];
        ev[7] = ev[5];
        ev[8] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b01,3'b000,2'b00,3'b010,1,0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); mem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL lw_wait cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [22:0] ev [0:4];
        op = 7'b0100011; funct3 = 3'b010;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b001,2'b00,3'b010,0,0);
        ev[2] = '0;
        ev[3] = pk(1,1,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,3'b010,1,0);
        ev[4] = pk(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = (i != 4); #1;
            checks++;
            if (i == 2) begin
                if ({alu_src_a, alu_src_b, alu_op, mem_req, reg_write, instr_done}
                    !== {2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL sw_memadr got a=%b b=%b op=%b req=%b rw=%b dn=%b exp a=10 b=01 op=00 req=0 rw=0 dn=0",
                             alu_src_a, alu_src_b, alu_op, mem_req, reg_write, instr_done);
                end
            end else if (obs !== ev[i]) begin
                failures++;
                $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_upper();
        logic [22:0] ev [0:3];
        logic [6:0]  ops [0:1];
        logic [2:0]  uf3 [0:1];
        ops = '{7'b0110111, 7'b0010111};
        uf3 = '{3'b001, 3'b000};
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct3 = 3'b101;
            ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b101,0,0);
            ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b100,2'b00,3'b101,0,0);
            ev[2] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b100,2'b11,uf3[k],0,0);
            ev[3] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b101,1,0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); mem_ready = 1'b1; #1;
                checks++;
                if (obs !== ev[i]) begin
                    failures++;
                    $display("FAIL upper%0d cyc%0d got=%h exp=%h", k, i, obs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_jalr();
        logic [22:0] ev [0:4];
        op = 7'b1100111; funct3 = 3'b000;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b000,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,2'b00,3'b000,0,0);
        ev[2] = pk(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b00,3'b000,0,0);
        ev[3] = pk(0,0,0,1,0,0,0,2'b01,2'b10,2'b00,3'b000,2'b00,3'b000,0,0);
        ev[4] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b000,1,0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL jalr cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_jal();
        logic [22:0] ev [0:3];
        op = 7'b1101111; funct3 = 3'b110;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b110,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b011,2'b00,3'b110,0,0);
        ev[2] = pk(0,0,0,1,0,0,0,2'b01,2'b10,2'b00,3'b000,2'b00,3'b110,0,0);
        ev[3] = pk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b110,1,0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL jal cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [22:0] ev [0:3];
        op = 7'b1100011; funct3 = 3'b001;
        ev[0] = pk(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b001,0,0);
        ev[1] = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b010,2'b00,3'b001,0,0);
        ev[2] = pk(0,0,0,0,1,0,0,2'b10,2'b00,2'b00,3'b000,2'b01,3'b001,1,0);
        ev[3] = pk(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b001,0,0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i != 3); #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL bne cyc%0d got=%h exp=%h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [22:0] ev_wr, ev_rst, ev_fetch;
        op = 7'b0100011; funct3 = 3'b010;
        ev_wr    = pk(1,1,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,3'b010,0,0);
        ev_rst   = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        ev_fetch = pk(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b010,0,0);
        repeat (3) begin
            @(negedge clk); mem_ready = 1'b1;
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (obs !== ev_wr) begin
            failures++;
            $display("FAIL abort_memwrite_wait got=%h exp=%h", obs, ev_wr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_write} !== 2'b00) begin
            failures++;
            $display("FAIL abort_async_drop got req=%b wr=%b exp req=0 wr=0", mem_req, mem_write);
        end
        checks++;
        if (obs !== ev_rst) begin
            failures++;
            $display("FAIL abort_reset_vec got=%h exp=%h", obs, ev_rst);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (obs !== ev_fetch) begin
            failures++;
            $display("FAIL abort_restart_fetch got=%h exp=%h", obs, ev_fetch);
        end
    endtask

    task automatic test_trap();
        logic [22:0] ev_dec, ev_trap, ev_rst;
        op = 7'b1111111; funct3 = 3'b011;
        ev_dec  = pk(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,2'b00,3'b011,0,0);
        ev_trap = pk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,3'b011,0,1);
        ev_rst  = pk(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,2'b00,3'b011,0,0);
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== ev_dec) begin
            failures++;
            $display("FAIL trap_decode got=%h exp=%h", obs, ev_dec);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
            checks++;
            if (obs !== ev_trap) begin
                failures++;
                $display("FAIL trap_sticky cyc%0d got=%h exp=%h", i, obs, ev_trap);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== ev_rst) begin
            failures++;
            $display("FAIL trap_reset_exit got=%h exp=%h", obs, ev_rst);
        end
        @(negedge clk); mem_ready = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        op = '0;
        funct3 = '0;
        mem_ready = 1'b0;
        test_reset();
        test_alu_r();
        test_alu_i();
        test_load_wait();
        test_store();
        test_upper();
        test_jalr();
        test_jal();
        test_branch();
        test_reset_mid_store();
        test_trap();
        test_alu_r();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
